// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NAND) among 4 requesters.
// Operands are captured in IDLE, evaluated in EXEC and held in RESP until accepted.
module logic_unit_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         req,
   input  logic [7:0]         op_bus,
   input  logic [4*WIDTH-1:0] a_bus,
   input  logic [4*WIDTH-1:0] b_bus,
   output logic [3:0]         gnt,
   output logic               rsp_valid,
   output logic [1:0]         rsp_id,
   output logic [WIDTH-1:0]   rsp_data,
   input  logic               rsp_ready,
   output logic               busy,
   output logic [15:0]        done_count
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [1:0]       r_ptr;
   logic [1:0]       r_id;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_rsp_valid;
   logic [1:0]       r_rsp_id;
   logic [WIDTH-1:0] r_rsp_data;
   logic [15:0]      r_done;

   logic             w_found;
   logic [1:0]       w_sel;
   logic [1:0]       w_idx;
   logic [WIDTH-1:0] w_result;

   // Scan from the farthest candidate back to ptr so the nearest set bit wins.
   always_comb begin
      w_found = 1'b0;
      w_sel   = r_ptr;
      w_idx   = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         w_idx = r_ptr + 2'(k);
         if (req[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_result = '0;
      unique case (r_op)
         2'b00:   w_result = r_a & r_b;
         2'b01:   w_result = r_a | r_b;
         2'b10:   w_result = r_a ^ r_b;
         2'b11:   w_result = ~(r_a & r_b);
         default: w_result = '0;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_found) w_state_next = StExec;
         StExec:  w_state_next = StResp;
         StResp:  if (rsp_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_ptr       <= '0;
         r_id        <= '0;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_done      <= '0;
      end else begin
         r_state <= w_state_next;
         unique case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_id <= w_sel;
                  r_op <= op_bus[2*w_sel +: 2];
                  r_a  <= a_bus[WIDTH*w_sel +: WIDTH];
                  r_b  <= b_bus[WIDTH*w_sel +: WIDTH];
               end
            end
            StExec: begin
               r_rsp_data  <= w_result;
               r_rsp_id    <= r_id;
               r_rsp_valid <= 1'b1;
            end
            StResp: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_ptr       <= r_id + 2'd1;
                  if (r_done != 16'hFFFF) r_done <= r_done + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign gnt        = (r_state == StExec) ? (4'b0001 << r_id) : 4'b0000;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_data   = r_rsp_data;
   assign busy       = (r_state != StIdle);
   assign done_count = r_done;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_logic_unit_arbiter;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [3:0]     req;
   logic [7:0]     op_bus;
   logic [4*W-1:0] a_bus;
   logic [4*W-1:0] b_bus;
   logic [3:0]     gnt;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_data;
   logic           rsp_ready;
   logic           busy;
   logic [15:0]    done_count;

   int checks = 0;
   int errors = 0;
   int exp_done;

   // Reference model state (transaction level)
   bit           m_busy;
   int           m_age;
   int           m_id;
   logic [W-1:0] m_data;
   int           m_ptr;
   int           m_done;

   typedef struct {
      logic [3:0]   vreq;
      int           id;
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   logic_unit_arbiter #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .op_bus     (op_bus),
      .a_bus      (a_bus),
      .b_bus      (b_bus),
      .gnt        (gnt),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_ready  (rsp_ready),
      .busy       (busy),
      .done_count (done_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_fn(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Put the wanted operands in one slot and noise in the others.
   task automatic load_slot(input int id, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
      op_bus = 8'($urandom);
      a_bus  = 32'($urandom);
      b_bus  = 32'($urandom);
      op_bus[2*id +: 2] = op;
      a_bus[W*id +: W]  = a;
      b_bus[W*id +: W]  = b;
   endtask

   task automatic do_txn(input vec_t v);
      load_slot(v.id, v.op, v.a, v.b);
      req       = v.vreq;
      rsp_ready = 1'b1;
      tick();
      check("txn_gnt", gnt, 32'(4'b0001 << v.id));
      check("txn_busy", busy, 1);
      req = 4'b0000;
      load_slot((v.id + 1) % 4, ~v.op, ~v.a, ~v.b);
      tick();
      check("txn_valid", rsp_valid, 1);
      check("txn_id", rsp_id, v.id);
      check("txn_data", rsp_data, v.exp);
      check("txn_gnt_resp", gnt, 0);
      tick();
      exp_done++;
      check("txn_valid_clr", rsp_valid, 0);
      check("txn_done", done_count, exp_done);
   endtask

   task automatic model_step();
      bit found;
      if (reset) begin
         m_busy = 0;
         m_age  = 0;
         m_ptr  = 0;
         m_done = 0;
      end else if (!m_busy) begin
         if (req != 4'b0000) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
               if (!found && req[(m_ptr + k) % 4]) begin
                  m_id  = (m_ptr + k) % 4;
                  found = 1;
               end
            end
            m_data = ref_fn(op_bus[2*m_id +: 2], a_bus[W*m_id +: W], b_bus[W*m_id +: W]);
            m_busy = 1;
            m_age  = 0;
         end
      end else if (m_age == 0) begin
         m_age = 1;
      end else if (rsp_ready) begin
         m_busy = 0;
         m_ptr  = (m_id + 1) % 4;
         if (m_done < 65535) m_done++;
      end
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{vreq: 4'b0001, id: 0, op: 2'b00, a: 8'hF0, b: 8'h3C, exp: 8'h30};
      vecs[1] = '{vreq: 4'b0100, id: 2, op: 2'b00, a: 8'hAA, b: 8'h0F, exp: 8'h0A};
      vecs[2] = '{vreq: 4'b0100, id: 2, op: 2'b01, a: 8'hAA, b: 8'h0F, exp: 8'hAF};
      vecs[3] = '{vreq: 4'b0100, id: 2, op: 2'b10, a: 8'hAA, b: 8'h0F, exp: 8'hA5};
      vecs[4] = '{vreq: 4'b0100, id: 2, op: 2'b11, a: 8'hAA, b: 8'h0F, exp: 8'hF5};

      reset     = 1'b1;
      req       = 4'b0000;
      op_bus    = '0;
      a_bus     = '0;
      b_bus     = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset then idle
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_gnt", gnt, 0);
         check("idle_valid", rsp_valid, 0);
         check("idle_busy", busy, 0);
         check("idle_done", done_count, 0);
      end

      exp_done = 0;
      for (int i = 0; i < 5; i++) do_txn(vecs[i]);

      // Round robin with all four requesting continuously
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_done  = 0;
      req       = 4'b1111;
      rsp_ready = 1'b1;
      op_bus    = 8'b11_10_01_00;
      a_bus     = 32'h4433_2211;
      b_bus     = 32'hFFFF_FFFF;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rr_gnt", gnt, 32'(4'b0001 << (i % 4)));
         tick();
         check("rr_id", rsp_id, i % 4);
         tick();
      end
      check("rr_done", done_count, 6);

      // Backpressure: requester 1 served, 1 and 2 pending while response stalls
      reset = 1'b1;
      tick();
      reset = 1'b0;
      load_slot(1, 2'b10, 8'h5A, 8'hFF);
      req = 4'b0010;
      tick();
      check("bp_gnt1", gnt, 4'b0010);
      req       = 4'b0110;
      rsp_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", rsp_valid, 1);
         check("bp_id", rsp_id, 1);
         check("bp_data", rsp_data, 8'hA5);
         check("bp_gnt", gnt, 0);
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_done", done_count, 1);
      tick();
      check("bp_next_gnt", gnt, 4'b0100);
      req = 4'b0000;
      tick();
      tick();

      // Reset in EXEC with a non-zero pointer
      reset = 1'b1;
      tick();
      reset = 1'b0;
      load_slot(2, 2'b00, 8'hFF, 8'h0F);
      req = 4'b0100;
      tick();
      req = 4'b0000;
      tick();
      tick();
      req = 4'b0100;
      tick();
      check("mid_exec_gnt", gnt, 4'b0100);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_busy", busy, 0);
      check("mid_valid", rsp_valid, 0);
      check("mid_gnt", gnt, 0);
      check("mid_done", done_count, 0);
      req = 4'b1001;
      tick();
      check("mid_ptr_gnt", gnt, 4'b0001);
      req = 4'b0000;
      tick();
      tick();

      // Randomized run against the reference model
      reset = 1'b1;
      model_step();
      tick();
      for (int c = 0; c < 3000; c++) begin
         reset     = ($urandom_range(0, 99) == 0);
         req       = 4'($urandom);
         op_bus    = 8'($urandom);
         a_bus     = 32'($urandom);
         b_bus     = 32'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         model_step();
         tick();
         check("rnd_gnt", gnt, (m_busy && m_age == 0) ? 32'(4'b0001 << m_id) : 0);
         check("rnd_valid", rsp_valid, (m_busy && m_age == 1) ? 1 : 0);
         check("rnd_busy", busy, m_busy ? 1 : 0);
         check("rnd_done", done_count, m_done);
         if (m_busy && m_age == 1) begin
            check("rnd_id", rsp_id, m_id);
            check("rnd_data", rsp_data, m_data);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
